deskew_ctrl: RTL
================

# deskew_ctrl

Multi-lane alignment sequencer for the 100GbE receive PCS. It sits downstream of the per-lane alignment-marker lock FSMs and upstream of the per-lane deskew FIFOs. It waits for all lanes to hold AM lock, then arms a deskew window and captures each lane's start-of-lane pulse. When every lane has arrived within the allowed skew, it releases the FIFO reads and asserts align status. Any lock loss or lane resync request restarts the sequence.

## Interface
Parameters:
- N_LANES, 20, number of PCS lanes (one AM lock FSM per lane)
- NB_SKEW, 6, width of skew counter and i_max_skew
- NB_FAIL_CNT, 8, width of saturating deskew-failure counter

Ports:
- i_clock  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_enable  in  1  global enable; when low, the FSM does not leave WAIT_LOCK
- i_valid  in  1  datapath valid; all state/counter updates occur only on cycles with i_valid=1
- i_am_lock  in  N_LANES  per-lane AM lock
- i_resync  in  N_LANES  per-lane resync request (pulse)
- i_start_of_lane  in  N_LANES  per-lane SOL pulse
- i_max_skew  in  NB_SKEW  maximum allowed skew, in valid cycles, between first and last SOL
- o_deskew_start  out  1  one-valid-cycle pulse when the window is armed
- o_fifo_wr_en  out  N_LANES  per-lane FIFO write enable; bit set from that lane's captured SOL onward
- o_fifo_rd_en  out  1  read enable for all FIFOs
- o_align_status  out  1  alignment achieved
- o_skew  out  NB_SKEW  measured skew of the last successful alignment
- o_fail_cnt  out  NB_FAIL_CNT  saturating count of failed deskew attempts

## Operation
States (one-hot): IDLE, WAIT_LOCK, WAIT_SOL, COLLECT, ALIGNED. Internal registers: seen[N_LANES] and skew_cnt.

- **IDLE:** entered on reset. Moves to WAIT_LOCK on the next valid cycle.
- **WAIT_LOCK:** seen=0, all enables low. When i_enable and &i_am_lock, go to WAIT_SOL.
- **WAIT_SOL:** o_deskew_start is high for the first valid cycle in this state only.
  - On the first valid cycle with i_start_of_lane≠0: seen<=sol and skew_cnt<=0.
  - If sol is all ones, go to ALIGNED with o_skew<=0.
  - Else, if i_max_skew==0, fail.
  - Else go to COLLECT.
- **COLLECT:** each valid cycle, cand=skew_cnt+1.
  - If (seen|sol) is all ones, go to ALIGNED with o_skew<=cand.
  - Else, if (sol & seen)≠0 (a lane repeated its SOL), fail.
  - Else, if cand==i_max_skew, fail.
  - Else skew_cnt<=cand and seen<=seen|sol.
- **Fail:** o_fail_cnt += 1, saturating at all ones. seen<=0, o_fifo_wr_en<=0, return to WAIT_SOL, and re-pulse o_deskew_start.
- **ALIGNED:** o_align_status=1, o_fifo_rd_en=1, o_fifo_wr_en all ones. The state holds until loss.
- **Loss (any state except IDLE/WAIT_LOCK):** !&i_am_lock or |i_resync on a valid cycle sends the FSM to WAIT_LOCK. On entering WAIT_LOCK, seen, o_fifo_wr_en, o_fifo_rd_en and o_align_status are cleared. o_skew and o_fail_cnt are kept.
- **Priority within one cycle:** loss > completion > repeated-SOL fail > timeout fail. Completion on the cycle cand==i_max_skew succeeds, so the window is inclusive.

## Timing
- **Reset values:** all outputs 0; state IDLE; seen=0; skew_cnt=0. o_fail_cnt and o_skew are cleared only by i_reset.
- **Registered outputs:** all outputs are registered and change on the clock edge that performs the transition.
  - o_fifo_wr_en[i] rises on the same edge that captures lane i's SOL into seen.
  - o_fifo_rd_en and o_align_status rise on the edge that enters ALIGNED.
- **Latency:** 1 valid cycle from the last lane's SOL to o_align_status=1.
- **Deskew start:** o_deskew_start is high during exactly one valid cycle per WAIT_SOL entry.
- **Stalls:** cycles with i_valid=0 freeze state, counters and outputs. SOL or resync bits asserted on such cycles are ignored.
- **Reset mid-operation:** returns to IDLE on the next edge, regardless of i_valid.

## Test plan
1. All 20 lanes locked; SOL on all lanes in the same cycle -> ALIGNED one valid cycle later, o_skew=0, o_fifo_rd_en=1, o_fail_cnt=0.
2. i_max_skew=5; lanes 0–9 SOL at t, lanes 10–19 SOL at t+5 -> ALIGNED, o_skew=5. Repeat with t+6 -> fail at t+5, o_fail_cnt=1, o_fifo_wr_en=0, new o_deskew_start pulse.
3. During COLLECT, lane 3 issues a second SOL before lane 19 arrives -> fail, o_fail_cnt increments, return to WAIT_SOL.
4. ALIGNED, then i_resync[7] pulses -> WAIT_LOCK next edge, o_align_status=0, o_fifo_rd_en=0. Re-locking yields a new deskew_start.
5. Drop i_am_lock[12] in WAIT_SOL, then restore -> returns to WAIT_LOCK, then re-arms. Toggle i_valid=0 every other cycle during COLLECT: the measured o_skew counts only valid cycles.
6. Force 300 consecutive failures with NB_FAIL_CNT=8 -> o_fail_cnt saturates at 255. Assert i_reset mid-COLLECT -> all outputs return to 0.

Source files
------------

// File: rtl/deskew_ctrl_if.sv
// deskew_ctrl_if: lock/SOL inputs and FIFO/status outputs of the
// 100GbE PCS lane deskew sequencer.
// master: AM lock + FIFO side (drives i_*, observes o_*)
// slave : deskew_ctrl (observes i_*, drives o_*)
interface deskew_ctrl_if #(
  parameter int N_LANES     = 20,
  parameter int NB_SKEW     = 6,
  parameter int NB_FAIL_CNT = 8
);
  logic                   i_enable;
  logic                   i_valid;
  logic [N_LANES-1:0]     i_am_lock;
  logic [N_LANES-1:0]     i_resync;
  logic [N_LANES-1:0]     i_start_of_lane;
  logic [NB_SKEW-1:0]     i_max_skew;
  logic                   o_deskew_start;
  logic [N_LANES-1:0]     o_fifo_wr_en;
  logic                   o_fifo_rd_en;
  logic                   o_align_status;
  logic [NB_SKEW-1:0]     o_skew;
  logic [NB_FAIL_CNT-1:0] o_fail_cnt;

  modport master (
    output i_enable, i_valid, i_am_lock,
    output i_resync, i_start_of_lane, i_max_skew,
    input  o_deskew_start, o_fifo_wr_en, o_fifo_rd_en,
    input  o_align_status, o_skew, o_fail_cnt
  );

  modport slave (
    input  i_enable, i_valid, i_am_lock,
    input  i_resync, i_start_of_lane, i_max_skew,
    output o_deskew_start, o_fifo_wr_en, o_fifo_rd_en,
    output o_align_status, o_skew, o_fail_cnt
  );
endinterface

// File: rtl/deskew_ctrl.sv
// deskew_ctrl: waits for AM lock on all lanes, arms a deskew window,
// collects per-lane SOL pulses and releases FIFO reads when aligned.
// Ports: i_clock, i_reset (sync, active-high), bus (deskew_ctrl_if.slave):
//   i_enable, i_valid, i_am_lock, i_resync, i_start_of_lane, i_max_skew
//   o_deskew_start, o_fifo_wr_en, o_fifo_rd_en, o_align_status,
//   o_skew, o_fail_cnt
module deskew_ctrl #(
  parameter int N_LANES     = 20,
  parameter int NB_SKEW     = 6,
  parameter int NB_FAIL_CNT = 8
) (
  input  logic         i_clock,
  input  logic         i_reset,
  deskew_ctrl_if.slave bus
);
  typedef enum logic [4:0] {
    IDLE      = 5'b00001,
    WAIT_LOCK = 5'b00010,
    WAIT_SOL  = 5'b00100,
    COLLECT   = 5'b01000,
    ALIGNED   = 5'b10000
  } state_t;

  state_t                 state_q;
  logic [N_LANES-1:0]     seen_q;
  logic [N_LANES-1:0]     wr_en_q;
  logic [NB_SKEW-1:0]     skew_cnt_q;
  logic [NB_SKEW-1:0]     skew_q;
  logic [NB_FAIL_CNT-1:0] fail_cnt_q;
  logic                   start_q;
  logic                   rd_en_q;
  logic                   align_q;

  logic [N_LANES-1:0]     sol;
  logic [N_LANES-1:0]     seen_d;
  logic [NB_SKEW-1:0]     cand_d;
  logic                   loss;
  logic                   done;
  logic                   fail;

  assign sol    = bus.i_start_of_lane;
  assign seen_d = seen_q | sol;
  assign cand_d = skew_cnt_q + 1'b1;
  assign loss   = (~&bus.i_am_lock) | (|bus.i_resync);

  // Completion beats any fail in the same cycle, so a window that
  // closes on cand == i_max_skew is still accepted.
  always_comb begin
    done = 1'b0;
    fail = 1'b0;
    if (state_q == WAIT_SOL && |sol) begin
      done = &sol;
      fail = !done && (bus.i_max_skew == '0);
    end else if (state_q == COLLECT) begin
      done = &seen_d;
      fail = !done &&
             ((|(sol & seen_q)) || (cand_d == bus.i_max_skew));
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= IDLE;
      seen_q     <= '0;
      wr_en_q    <= '0;
      skew_cnt_q <= '0;
      skew_q     <= '0;
      fail_cnt_q <= '0;
      start_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      align_q    <= 1'b0;
    end else if (bus.i_valid) begin
      start_q <= 1'b0;
      if (loss && state_q != IDLE && state_q != WAIT_LOCK) begin
        state_q <= WAIT_LOCK;
        seen_q  <= '0;
        wr_en_q <= '0;
        rd_en_q <= 1'b0;
        align_q <= 1'b0;
      end else if (done) begin
        state_q <= ALIGNED;
        seen_q  <= seen_d;
        wr_en_q <= '1;
        rd_en_q <= 1'b1;
        align_q <= 1'b1;
        skew_q  <= (state_q == COLLECT) ? cand_d : '0;
      end else if (fail) begin
        state_q <= WAIT_SOL;
        start_q <= 1'b1;
        seen_q  <= '0;
        wr_en_q <= '0;
        if (fail_cnt_q != '1) begin
          fail_cnt_q <= fail_cnt_q + 1'b1;
        end
      end else begin
        unique case (state_q)
          IDLE: state_q <= WAIT_LOCK;
          WAIT_LOCK: begin
            if (bus.i_enable && &bus.i_am_lock) begin
              state_q <= WAIT_SOL;
              start_q <= 1'b1;
            end
          end
          WAIT_SOL: begin
            if (|sol) begin
              state_q    <= COLLECT;
              seen_q     <= sol;
              wr_en_q    <= sol;
              skew_cnt_q <= '0;
            end
          end
          COLLECT: begin
            skew_cnt_q <= cand_d;
            seen_q     <= seen_d;
            wr_en_q    <= seen_d;
          end
          ALIGNED: state_q <= ALIGNED;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.o_deskew_start = start_q;
  assign bus.o_fifo_wr_en   = wr_en_q;
  assign bus.o_fifo_rd_en   = rd_en_q;
  assign bus.o_align_status = align_q;
  assign bus.o_skew         = skew_q;
  assign bus.o_fail_cnt     = fail_cnt_q;
endmodule
